split_slave: RTL

- Split-capable serial bus slave; the responder end of the 1-bit master/bus protocol.
- Drives the bus `sN_split`/`split_grant` path that current slaves leave unused (tied to 0).
- Deserialises address and write data from `swdata`, stores into internal memory, and serialises read data on `srdata`.
- On reads it asserts `ssplit` while its internal read latency elapses, so the bus can serve other masters, then resumes on `split_grant`.

---
 rtl/split_slave_pkg.sv | 23 ++
 rtl/split_slave_mem.sv | 43 ++++
 rtl/split_slave.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/split_slave_pkg.sv
// Shared types and helpers for the split-capable serial bus slave.
package split_slave_pkg;

    // Transaction phases of the slave FSM.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR       = 3'd1,
        ST_WDATA      = 3'd2,
        ST_SPLIT      = 3'd3,
        ST_GRANT_WAIT = 3'd4,
        ST_RDATA      = 3'd5
    } state_t;

    // Value of smode on the first mvalid cycle of a transaction.
    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Width of a counter that must be able to hold max_count itself.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/split_slave_mem.sv
// Word storage for split_slave: one shared address, synchronous write and
// registered read. Addresses at or above MEM_SIZE never write and read as 0.
// The zero mask sits after the read register so the array maps onto block RAM.
module split_slave_mem #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 4096
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Index width assumes MEM_SIZE <= 2**ADDR_WIDTH.
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    logic [DATA_WIDTH-1:0] mem_array [MEM_SIZE];
    logic [DATA_WIDTH-1:0] q_reg;
    logic                  hit_reg;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    assign in_range = ({1'b0, addr} < MEM_LIMIT);
    assign idx      = addr[IDX_W-1:0];

    // Guarded write and registered read of the storage array.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem_array[idx] <= wdata;
        end
        if (re) begin
            q_reg   <= mem_array[idx];
            hit_reg <= in_range;
        end
    end

    assign rdata = hit_reg ? q_reg : '0;

endmodule

// File: rtl/split_slave.sv
// Split-capable serial bus slave. Shifts in address/write data LSB first,
// and on reads raises ssplit while the read latency elapses, then streams
// the word out on srdata once the bus hands the master back (split_grant).
// With SPLIT_EN=0 the SPLIT state is a silent one-cycle fetch that leads
// straight to RDATA. Counting the first address bit as cycle 1, the first
// svalid cycle (split, grant already high) is ADDR_WIDTH+READ_LATENCY+2.
module split_slave
    import split_slave_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_SIZE     = 4096,
    parameter int READ_LATENCY = 4,
    parameter int SPLIT_EN     = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic swdata,
    input  logic smode,
    input  logic mvalid,
    input  logic split_grant,
    output logic srdata,
    output logic svalid,
    output logic sready,
    output logic ssplit
);

    localparam int CNT_W = cnt_width((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_DONE = CNT_W'(DATA_WIDTH);
    localparam logic [7:0]       LAT_INIT  = (SPLIT_EN != 0) ? 8'(READ_LATENCY) : 8'd1;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [7:0]            lat_reg, lat_next;
    logic                  mode_reg, mode_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [DATA_WIDTH-1:0] rword_reg, rword_next;
    logic                  srdata_reg, srdata_next;
    logic                  svalid_reg, ssplit_reg, sready_reg;

    logic [ADDR_WIDTH-1:0] addr_shift;
    logic [DATA_WIDTH-1:0] wdata_shift;
    logic                  addr_done;
    logic                  addr_mode;
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // LSB-first shift: each new bit enters at the top, so after a full
    // frame the first bit received sits at position 0.
    generate
        if (ADDR_WIDTH == 1) begin : g_addr_one
            assign addr_shift = swdata;
        end else begin : g_addr_many
            assign addr_shift = {swdata, addr_reg[ADDR_WIDTH-1:1]};
        end
        if (DATA_WIDTH == 1) begin : g_data_one
            assign wdata_shift = swdata;
        end else begin : g_data_many
            assign wdata_shift = {swdata, wdata_reg[DATA_WIDTH-1:1]};
        end
    endgenerate

    // The write uses the completed data word on its last bit; a read is
    // issued on the last address bit using the address including that bit.
    assign mem_addr = mem_we ? addr_reg : addr_shift;

    split_slave_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (wdata_shift),
        .rdata (mem_rdata)
    );

    // Next-state, shift/counter updates and memory strobes.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        lat_next    = lat_reg;
        mode_next   = mode_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        rword_next  = rword_reg;
        srdata_next = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        addr_done   = 1'b0;
        addr_mode   = mode_reg;

        case (state_reg)
            ST_IDLE: begin
                if (mvalid) begin
                    mode_next  = smode;
                    addr_next  = addr_shift;
                    cnt_next   = CNT_W'(1);
                    state_next = ST_ADDR;
                    if (ADDR_WIDTH == 1) begin
                        addr_done = 1'b1;
                        addr_mode = smode;
                    end
                end
            end
            ST_ADDR: begin
                if (!mvalid) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    addr_next = addr_shift;
                    if (cnt_reg == ADDR_LAST) begin
                        addr_done = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (!mvalid) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    wdata_next = wdata_shift;
                    if (cnt_reg == DATA_LAST) begin
                        mem_we     = 1'b1;
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_SPLIT: begin
                if (lat_reg == 8'd1) begin
                    lat_next = '0;
                    if (SPLIT_EN != 0) begin
                        rword_next = mem_rdata;
                        state_next = ST_GRANT_WAIT;
                    end else begin
                        srdata_next = mem_rdata[0];
                        rword_next  = mem_rdata >> 1;
                        cnt_next    = CNT_W'(1);
                        state_next  = ST_RDATA;
                    end
                end else begin
                    lat_next = lat_reg - 8'd1;
                end
            end
            ST_GRANT_WAIT: begin
                if (split_grant) begin
                    srdata_next = rword_reg[0];
                    rword_next  = rword_reg >> 1;
                    cnt_next    = CNT_W'(1);
                    state_next  = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (cnt_reg == DATA_DONE) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    srdata_next = rword_reg[0];
                    rword_next  = rword_reg >> 1;
                    cnt_next    = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Address complete: writes collect data, reads start the fetch.
        if (addr_done) begin
            cnt_next = '0;
            if (addr_mode == MODE_WRITE) begin
                state_next = ST_WDATA;
            end else begin
                mem_re     = 1'b1;
                lat_next   = LAT_INIT;
                state_next = ST_SPLIT;
            end
        end
    end

    // State and registered outputs; status flags follow the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            lat_reg    <= '0;
            mode_reg   <= MODE_READ;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rword_reg  <= '0;
            srdata_reg <= 1'b0;
            svalid_reg <= 1'b0;
            ssplit_reg <= 1'b0;
            sready_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            lat_reg    <= lat_next;
            mode_reg   <= mode_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            rword_reg  <= rword_next;
            srdata_reg <= srdata_next;
            svalid_reg <= (state_next == ST_RDATA);
            ssplit_reg <= (state_next == ST_SPLIT) && (SPLIT_EN != 0);
            sready_reg <= (state_next == ST_IDLE);
        end
    end

    assign srdata = srdata_reg;
    assign svalid = svalid_reg;
    assign ssplit = ssplit_reg;
    assign sready = sready_reg;

endmodule
